// File: rtl/afe_pkg.sv
// afe_pkg: shared AGC types and gain clamp helper
package afe_pkg;
  typedef enum logic [2:0] {IDLE, ACCUM, EVAL, REQUEST, WAIT_ACK, WAIT_DONE, SETTLE} agc_state_t;
  typedef logic signed [7:0] gain_db_t;
  function automatic gain_db_t clamp_gain(input logic signed [8:0] v, input gain_db_t lo, input gain_db_t hi);
    logic signed [8:0] lo9, hi9;
    lo9 = {lo[7], lo};
    hi9 = {hi[7], hi};
    return v < lo9 ? lo : v > hi9 ? hi : gain_db_t'(v[7:0]);
  endfunction
endpackage

// File: rtl/agc_peak_detector.sv
// agc_peak_detector: saturating sample magnitude, running window peak and window counter
module agc_peak_detector #(
  parameter int SAMPLE_W   = 12,
  parameter int WINDOW_LEN = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic                       sample_valid,
  output logic [SAMPLE_W-2:0]        peak,
  output logic                       window_done
);
  localparam int CW = $clog2(WINDOW_LEN);
  logic [CW-1:0] count;
  logic [SAMPLE_W-1:0] neg;
  logic [SAMPLE_W-2:0] mag;
  logic take;
  assign neg = -sample;
  // the most negative code has no positive twin, so it saturates to full scale
  assign mag = !sample[SAMPLE_W-1] ? sample[SAMPLE_W-2:0] :
               neg[SAMPLE_W-1] ? '1 : neg[SAMPLE_W-2:0];
  assign take = en && sample_valid;
  assign window_done = take && count == CW'(WINDOW_LEN - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      peak  <= '0;
      count <= '0;
    end else if (clear) begin
      peak  <= '0;
      count <= '0;
    end else if (take) begin
      peak  <= mag > peak ? mag : peak;
      count <= window_done ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/agc_scheduler.sv
// agc_scheduler: windowed peak AGC sequencer driving the AFE gain controller handshake
module agc_scheduler import afe_pkg::*; #(
  parameter int SAMPLE_W      = 12,
  parameter int WINDOW_LEN    = 1024,
  parameter int SETTLE_CYCLES = 256,
  parameter int ACK_TIMEOUT   = 8,
  parameter int GAIN_MIN      = -8,
  parameter int GAIN_MAX      = 40,
  parameter int GAIN_INIT     = 0,
  parameter int STEP_UP       = 2,
  parameter int STEP_DOWN     = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable_i,
  input  logic                       manual_i,
  input  logic signed [7:0]          manual_gain_dB_i,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic                       sample_valid_i,
  input  logic [SAMPLE_W-2:0]        thresh_hi_i,
  input  logic [SAMPLE_W-2:0]        thresh_lo_i,
  input  logic                       afe_busy_i,
  output logic signed [7:0]          gain_dB_o,
  output logic                       set_gain_o,
  output logic                       busy_o,
  output logic                       overload_o,
  output logic                       timeout_err_o
);
  localparam int AW = $clog2(ACK_TIMEOUT) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  agc_state_t state;
  gain_db_t target, man_tgt, eval_tgt;
  logic signed [8:0] g9, eval_sum;
  logic [SAMPLE_W-2:0] peak;
  logic window_done, over, under;
  logic [AW-1:0] ack_cnt;
  logic [SW-1:0] settle_cnt;
  agc_peak_detector #(.SAMPLE_W(SAMPLE_W), .WINDOW_LEN(WINDOW_LEN)) u_peak (
    .clk(clk),
    .rst_n(rst_n),
    .clear(state != ACCUM),
    .en(state == ACCUM && !manual_i),
    .sample(sample_i),
    .sample_valid(sample_valid_i),
    .peak(peak),
    .window_done(window_done)
  );
  always_comb begin
    over     = peak >= thresh_hi_i;
    under    = peak < thresh_lo_i;
    g9       = {gain_dB_o[7], gain_dB_o};
    eval_sum = over ? g9 - 9'(STEP_DOWN) : under ? g9 + 9'(STEP_UP) : g9;
    eval_tgt = clamp_gain(eval_sum, 8'(GAIN_MIN), 8'(GAIN_MAX));
    man_tgt  = clamp_gain({manual_gain_dB_i[7], manual_gain_dB_i}, 8'(GAIN_MIN), 8'(GAIN_MAX));
  end
  assign busy_o = state != IDLE && state != ACCUM;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      gain_dB_o     <= 8'(GAIN_INIT);
      target        <= '0;
      set_gain_o    <= 1'b0;
      overload_o    <= 1'b0;
      timeout_err_o <= 1'b0;
      ack_cnt       <= '0;
      settle_cnt    <= '0;
    end else begin
      set_gain_o <= 1'b0;
      case (state)
        IDLE: if (enable_i) state <= ACCUM;
        ACCUM:
          if (manual_i) begin
            if (man_tgt != gain_dB_o) begin
              target <= man_tgt;
              state  <= REQUEST;
            end
          end else if (window_done) state <= EVAL;
          else if (!enable_i) state <= IDLE;
        EVAL: begin
          overload_o <= over;
          target     <= eval_tgt;
          state      <= eval_tgt == gain_dB_o ? ACCUM : REQUEST;
        end
        REQUEST:
          if (!afe_busy_i) begin
            gain_dB_o  <= target;
            set_gain_o <= 1'b1;
            ack_cnt    <= '0;
            state      <= WAIT_ACK;
          end
        WAIT_ACK:
          if (afe_busy_i) state <= WAIT_DONE;
          else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
            timeout_err_o <= 1'b1;
            settle_cnt    <= '0;
            state         <= SETTLE;
          end else ack_cnt <= ack_cnt + 1'b1;
        WAIT_DONE:
          if (!afe_busy_i) begin
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        SETTLE:
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state <= enable_i ? ACCUM : IDLE;
          else settle_cnt <= settle_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_agc_scheduler.sv
// tb_agc_scheduler: randomized scoreboard bench with a gain controller model and AGC reference model
module tb_agc_scheduler;
  localparam int SW = 12, WL = 64, SC = 256, AT = 8;
  logic clk = 0, rst_n = 0, enable_i = 0, manual_i = 0, sample_valid_i = 0, afe_busy_i;
  logic signed [7:0] manual_gain_dB_i = 0;
  logic signed [SW-1:0] sample_i = 0;
  logic [SW-2:0] thresh_hi_i = 11'd1500, thresh_lo_i = 11'd200;
  logic signed [7:0] gain_dB_o;
  logic set_gain_o, busy_o, overload_o, timeout_err_o;
  int checks = 0, errors = 0, cyc = 0, strobes = 0, last_cyc = 0, busy_cnt = 0, m_gain = 0;
  bit lat_chk = 0, no_ack = 0, force_busy = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  agc_scheduler #(.SAMPLE_W(SW), .WINDOW_LEN(WL), .SETTLE_CYCLES(SC), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .manual_i(manual_i),
    .manual_gain_dB_i(manual_gain_dB_i), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .thresh_hi_i(thresh_hi_i), .thresh_lo_i(thresh_lo_i), .afe_busy_i(afe_busy_i),
    .gain_dB_o(gain_dB_o), .set_gain_o(set_gain_o), .busy_o(busy_o),
    .overload_o(overload_o), .timeout_err_o(timeout_err_o)
  );

  // gain controller: busy from the cycle after a strobe, for 6 cycles
  assign afe_busy_i = force_busy || busy_cnt != 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) busy_cnt <= 0;
    else if (set_gain_o && !no_ack) busy_cnt <= 6;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (rst_n && set_gain_o) begin
      strobes++;
      if (exp_q.size() == 0) check("unexpected strobe", 1, 0);
      else check("strobe gain", int'(gain_dB_o), exp_q.pop_front());
      if (lat_chk) begin
        check("window-to-strobe latency", cyc - last_cyc - 1, 2);
        lat_chk = 0;
      end
    end

  function automatic int clampm(input int v);
    return v < -8 ? -8 : v > 40 ? 40 : v;
  endfunction

  function automatic int abs_sat(input int s);
    return s == -2048 ? 2047 : s < 0 ? -s : s;
  endfunction

  function automatic int eval_gain(input int pk);
    int t;
    t = pk >= int'(thresh_hi_i) ? m_gain - 6 : pk < int'(thresh_lo_i) ? m_gain + 2 : m_gain;
    return clampm(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    while (busy_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(n < 2000), 1);
  endtask

  task automatic wait_strobe(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!set_gain_o && n < 12);
    check(name, set_gain_o, 1);
  endtask

  task automatic window(input bit is_fix, input int mag, input bit do_wait);
    int n = 0, pk = 0, s, t;
    while (n < WL) begin
      tick();
      sample_valid_i = $urandom_range(0, 3) != 0;
      s = is_fix ? mag : int'($urandom_range(0, 2 * mag)) - mag;
      sample_i = s[SW-1:0];
      if (sample_valid_i) begin
        n++;
        pk = abs_sat(s) > pk ? abs_sat(s) : pk;
      end
    end
    last_cyc = cyc;
    t = eval_gain(pk);
    if (t != m_gain) begin
      exp_q.push_back(t);
      m_gain = t;
      lat_chk = 1;
    end
    tick();
    sample_valid_i = 0;
    if (do_wait) begin
      wait_idle("window sequence ends");
      check("overload", overload_o, int'(pk >= int'(thresh_hi_i)));
    end
  endtask

  task automatic set_manual(input int v);
    int t;
    t = clampm(v);
    tick();
    manual_i = 1;
    manual_gain_dB_i = v[7:0];
    if (t != m_gain) begin
      exp_q.push_back(t);
      m_gain = t;
    end
  endtask

  task automatic manual_off();
    tick();
    manual_i = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, c;
    repeat (3) @(posedge clk);
    #3;
    check("reset gain", int'(gain_dB_o), 0);
    check("reset set_gain", set_gain_o, 0);
    check("reset busy", busy_o, 0);
    check("reset overload", overload_o, 0);
    check("reset timeout", timeout_err_o, 0);
    tick();
    rst_n = 1;
    enable_i = 1;
    // first low window raises gain by STEP_UP, then measure settle holdoff
    window(1, 100, 0);
    wait_strobe("first strobe");
    n = 0;
    while (!afe_busy_i && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (afe_busy_i && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (busy_o && n < 1000) begin @(negedge clk); n++; end
    check("settle length", n, SC + 1);
    check("gain after first window", int'(gain_dB_o), 2);
    check("overload after low window", overload_o, 0);
    // gain at ceiling: low windows change nothing, full-scale negative drops by STEP_DOWN
    set_manual(40);
    wait_idle("manual 40");
    manual_off();
    base = strobes;
    window(1, 100, 1);
    window(0, 150, 1);
    check("no strobe at ceiling", strobes, base);
    check("gain held at 40", int'(gain_dB_o), 40);
    window(1, -2048, 1);
    check("gain after overload", int'(gain_dB_o), 34);
    // floor clamp
    set_manual(-6);
    wait_idle("manual -6");
    manual_off();
    window(1, -2048, 1);
    check("gain clamped to floor", int'(gain_dB_o), -8);
    base = strobes;
    window(1, 2000, 1);
    check("no strobe at floor", strobes, base);
    // manual override latency and clamping
    set_manual(20);
    c = cyc;
    wait_strobe("manual strobe");
    check("manual strobe within 2 cycles", int'(cyc - c <= 2), 1);
    wait_idle("manual 20");
    set_manual(100);
    wait_idle("manual 100");
    check("manual clamp high", int'(gain_dB_o), 40);
    set_manual(-128);
    wait_idle("manual -128");
    check("manual clamp low", int'(gain_dB_o), -8);
    manual_off();
    // random thresholds (including lo > hi) and sample magnitudes
    for (int i = 0; i < 8; i++) begin
      tick();
      thresh_lo_i = 11'($urandom_range(0, 2047));
      thresh_hi_i = 11'($urandom_range(0, 2047));
      window(0, int'($urandom_range(0, 2047)), 1);
    end
    check("no timeout yet", timeout_err_o, 0);
    // ACK timeout: controller never asserts busy
    no_ack = 1;
    set_manual(m_gain == 10 ? 12 : 10);
    wait_strobe("strobe before timeout");
    n = 0;
    while (!timeout_err_o && n < 20) begin @(negedge clk); n++; end
    check("timeout delay", n, AT);
    check("settling after timeout", busy_o, 1);
    wait_idle("timeout sequence");
    no_ack = 0;
    // strobe held off while controller busy
    tick();
    force_busy = 1;
    set_manual(m_gain == 16 ? 18 : 16);
    base = strobes;
    repeat (20) @(negedge clk);
    check("no strobe while afe busy", strobes, base);
    check("busy while requesting", busy_o, 1);
    tick();
    force_busy = 0;
    wait_idle("released request");
    check("strobe after release", strobes, base + 1);
    check("timeout sticky", timeout_err_o, 1);
    // asynchronous reset during WAIT_DONE
    set_manual(m_gain == 30 ? 32 : 30);
    wait_strobe("strobe before reset");
    repeat (3) @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    check("mid reset gain", int'(gain_dB_o), 0);
    check("mid reset set_gain", set_gain_o, 0);
    check("mid reset busy", busy_o, 0);
    check("mid reset timeout", timeout_err_o, 0);
    check("mid reset overload", overload_o, 0);
    exp_q.delete();
    m_gain = 0;
    manual_i = 0;
    enable_i = 0;
    tick();
    rst_n = 1;
    // enable dropped during SETTLE: sequence finishes, then IDLE
    tick();
    enable_i = 1;
    set_manual(24);
    wait_strobe("strobe before disable");
    repeat (20) @(negedge clk);
    tick();
    enable_i = 0;
    n = 0;
    while (busy_o && n < 1000) begin @(negedge clk); n++; end
    check("settle completes after disable", int'(n > 200 && n < 300), 1);
    manual_off();
    base = strobes;
    for (int i = 0; i < WL + 8; i++) begin
      tick();
      sample_valid_i = 1;
      sample_i = 12'h800;
    end
    tick();
    sample_valid_i = 0;
    repeat (5) @(negedge clk);
    check("idle ignores samples", strobes, base);
    check("idle overload unchanged", overload_o, 0);
    check("idle not busy", busy_o, 0);
    check("gain held in idle", int'(gain_dB_o), 24);
    check("pending expectations", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
